// File: rtl/interrupt_ctrl_pkg.sv
// Shared constants for interrupt_ctrl: the MMIO word map, the privilege
// encodings and the take-FSM state encoding.
package int_ctrl_pkg;

  // MMIO word selects
  localparam logic [2:0] ADR_MTIME_LO    = 3'd0;
  localparam logic [2:0] ADR_MTIME_HI    = 3'd1;
  localparam logic [2:0] ADR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] ADR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] ADR_EXT_PEND    = 3'd4;
  localparam logic [2:0] ADR_STATUS      = 3'd5;

  // Privilege levels
  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_U = 2'b00;

  // Take FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_PC = 2'd1,
    TAKEN   = 2'd2
  } take_state_t;

endpackage

// File: rtl/interrupt_ctrl_if.sv
// MMIO bus between a bus master and interrupt_ctrl: write strobe, word
// select, write data and combinational read data.
interface interrupt_ctrl_if;
  logic        io_we;
  logic [2:0]  io_adr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport master (output io_we, output io_adr, output io_wdata, input io_rdata);
  modport slave  (input io_we, input io_adr, input io_wdata, output io_rdata);
endinterface

// File: rtl/interrupt_ctrl_mtimer.sv
// Machine timer: prescaler, 64-bit mtime/mtimecmp with MMIO write access,
// and the registered timer-pending compare.
module mtimer
  import int_ctrl_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [2:0]  adr,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        leq
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  logic [15:0] presc_reg;
  logic        tick;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp_next;

  assign tick = (presc_reg == PRESC_LAST);

  // Prescaler counts 0..PRESCALE-1 and wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_reg <= '0;
    else if (tick) presc_reg <= '0;
    else presc_reg <= presc_reg + 16'd1;
  end

  // Next mtime/mtimecmp: an MMIO write to a half overrides the increment,
  // and the other half keeps its pre-increment value (no carry)
  always_comb begin
    mtime_next    = mtime;
    mtimecmp_next = mtimecmp;
    if (tick) mtime_next = mtime + 64'd1;
    if (we) begin
      case (adr)
        ADR_MTIME_LO:    mtime_next = {mtime[63:32], wdata};
        ADR_MTIME_HI:    mtime_next = {wdata, mtime[31:0]};
        ADR_MTIMECMP_LO: mtimecmp_next = {mtimecmp[63:32], wdata};
        ADR_MTIMECMP_HI: mtimecmp_next = {wdata, mtimecmp[31:0]};
        default: ;
      endcase
    end
  end

  // Timer registers; the compare sees the already-updated values one
  // cycle after they change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime    <= '0;
      mtimecmp <= '1;
      leq      <= 1'b0;
    end else begin
      mtime    <= mtime_next;
      mtimecmp <= mtimecmp_next;
      leq      <= (mtimecmp <= mtime);
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Machine-level interrupt source and arbiter feeding the CSR array.
// Optional macro INT_CTRL_EXT_EDGE_EN: when defined the external request is
// edge-latched into a pending flop cleared over MMIO; otherwise level mode.
module interrupt_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int PRESCALE    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_int_in,
  input  logic             csr_rmie,
  input  logic             csr_meie,
  input  logic             csr_mtie,
  input  logic             cpu_stat_pc,
  input  logic             cmd_mret_ex,
  interrupt_ctrl_if.slave  io,
  output logic             g_interrupt,
  output logic             g_interrupt_1shot,
  output logic             frc_cntr_val_leq,
  output logic             interrupts_in_pc_state,
  output logic [1:0]       g_interrupt_priv
);

  logic [63:0]             mtime;
  logic [63:0]             mtimecmp;
  logic [SYNC_STAGES-1:0]  sync_reg;
  logic                    ext_sync;
  logic                    g_interrupt_d;
  logic                    en_pend;
  logic                    ext_read;
  take_state_t             state_reg;

  mtimer #(.PRESCALE(PRESCALE)) u_mtimer (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (io.io_we),
    .adr      (io.io_adr),
    .wdata    (io.io_wdata),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .leq      (frc_cntr_val_leq)
  );

  // Synchroniser chain on the asynchronous external request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= '0;
    else sync_reg <= {sync_reg[SYNC_STAGES-2:0], ext_int_in};
  end

  assign ext_sync = sync_reg[SYNC_STAGES-1];

`ifdef INT_CTRL_EXT_EDGE_EN
  logic ext_sync_d;
  logic pend_reg;
  logic ext_clr;

  assign ext_clr = io.io_we && (io.io_adr == ADR_EXT_PEND) && io.io_wdata[0];

  // Edge-latched pending flop; a rising edge beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_sync_d <= 1'b0;
      pend_reg   <= 1'b0;
    end else begin
      ext_sync_d <= ext_sync;
      if (ext_sync && !ext_sync_d) pend_reg <= 1'b1;
      else if (ext_clr) pend_reg <= 1'b0;
    end
  end

  assign g_interrupt = pend_reg;
  assign ext_read    = pend_reg;
`else
  assign g_interrupt = ext_sync;
  assign ext_read    = ext_sync;
`endif

  // Previous g_interrupt for the rising-edge one-shot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) g_interrupt_d <= 1'b0;
    else g_interrupt_d <= g_interrupt;
  end

  assign g_interrupt_1shot = g_interrupt & ~g_interrupt_d;
  assign g_interrupt_priv  = PRIV_M;
  assign en_pend = (g_interrupt & csr_meie) | (frc_cntr_val_leq & csr_mtie);

  // Take FSM: one registered take-pulse per interrupt, aligned to the PC state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg              <= IDLE;
      interrupts_in_pc_state <= 1'b0;
    end else begin
      interrupts_in_pc_state <= 1'b0;
      case (state_reg)
        IDLE: if (en_pend) state_reg <= WAIT_PC;
        WAIT_PC: begin
          if (!en_pend) begin
            state_reg <= IDLE;
          end else if (cpu_stat_pc && csr_rmie) begin
            interrupts_in_pc_state <= 1'b1;
            state_reg              <= TAKEN;
          end
        end
        TAKEN: if (cmd_mret_ex && cpu_stat_pc) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Side-effect-free MMIO read mux
  always_comb begin
    io.io_rdata = 32'd0;
    case (io.io_adr)
      ADR_MTIME_LO:    io.io_rdata = mtime[31:0];
      ADR_MTIME_HI:    io.io_rdata = mtime[63:32];
      ADR_MTIMECMP_LO: io.io_rdata = mtimecmp[31:0];
      ADR_MTIMECMP_HI: io.io_rdata = mtimecmp[63:32];
      ADR_EXT_PEND:    io.io_rdata = {31'd0, ext_read};
      ADR_STATUS:      io.io_rdata = {29'd0, state_reg, frc_cntr_val_leq};
      default:         io.io_rdata = 32'd0;
    endcase
  end

endmodule
